// File: rtl/array_pkg.sv
// rtl/array_pkg.sv - shared nucleotide codes, code check and feeder state type
//
// Purpose: constants and types shared by the array feeder and its unpacker.
// Ports:   none (package).
package array_pkg;

  localparam int LENGTH_CHAR = 3;

  localparam logic [LENGTH_CHAR-1:0] CODE_PAD = 3'b000;
  localparam logic [LENGTH_CHAR-1:0] CODE_A   = 3'b001;
  localparam logic [LENGTH_CHAR-1:0] CODE_G   = 3'b010;
  localparam logic [LENGTH_CHAR-1:0] CODE_T   = 3'b011;
  localparam logic [LENGTH_CHAR-1:0] CODE_C   = 3'b100;
  localparam logic [LENGTH_CHAR-1:0] CODE_N   = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_QUERY,
    LOAD_SUB,
    FLUSH,
    DONE
  } state_t;

  // PAD and the two unassigned codes are not valid sequence characters.
  function automatic logic is_bad_code(input logic [LENGTH_CHAR-1:0] code);
    return (code == CODE_PAD) || (code == 3'b110) || (code == 3'b111);
  endfunction

endpackage

// File: rtl/word_unpacker.sv
// rtl/word_unpacker.sv - shift register holding the not-yet-emitted lanes of a word
//
// Purpose: holds lanes 1..LANES-1 of an accepted word (lane 0 is emitted
//          straight from the input by the feeder) and hands them out one per
//          advance, lowest lane first.
// Ports:   com_clk, reset       clock, synchronous active-high reset
//          load, load_data      capture a full packed word (lane 0 dropped)
//          load_last            word carried in_last
//          advance              consume the head lane
//          discard              drop all remaining lanes
//          empty                no lanes left
//          head                 lane currently at the front
//          last_lane            head is the final lane of its word
//          word_last            held word carried in_last
module word_unpacker #(
  parameter int LANE_W = 3,
  parameter int LANES  = 5
) (
  input  logic                      com_clk,
  input  logic                      reset,
  input  logic                      load,
  input  logic [LANES*LANE_W-1:0]   load_data,
  input  logic                      load_last,
  input  logic                      advance,
  input  logic                      discard,
  output logic                      empty,
  output logic [LANE_W-1:0]         head,
  output logic                      last_lane,
  output logic                      word_last
);

  localparam int CW = $clog2(LANES + 1);

  logic [LANES*LANE_W-1:0] shift;
  logic [CW-1:0]           remaining;
  logic                    last_q;

  always_ff @(posedge com_clk) begin
    if (reset) begin
      shift     <= '0;
      remaining <= '0;
      last_q    <= 1'b0;
    end else if (discard) begin
      remaining <= '0;
      last_q    <= 1'b0;
    end else if (load) begin
      shift     <= load_data >> LANE_W;
      remaining <= CW'(LANES - 1);
      last_q    <= load_last;
    end else if (advance && (remaining != '0)) begin
      shift     <= shift >> LANE_W;
      remaining <= remaining - 1'b1;
    end
  end

  assign empty     = (remaining == '0);
  assign head      = shift[LANE_W-1:0];
  assign last_lane = (remaining == CW'(1));
  assign word_last = last_q;

endmodule

// File: rtl/array_feeder.sv
// rtl/array_feeder.sv - streams query, subject and flush codes into a systolic array
//
// Purpose: accepts packed nucleotide words, unpacks them one code per cycle,
//          feeds query_len query codes then sub_len subject codes, then pushes
//          LENGTH PAD codes to drain the array and pulses done.
// Ports:   com_clk, reset               clock, synchronous active-high reset
//          start, query_len, sub_len    job start and lengths (sampled in IDLE)
//          in_data, in_valid, in_ready,
//          in_last                      packed word input handshake
//          query_char_out, query_enable query code to the array
//          sub_char_out, sub_enable     subject / flush code to the array
//          busy, done, error            job status
module array_feeder
  import array_pkg::state_t, array_pkg::IDLE, array_pkg::LOAD_QUERY, array_pkg::LOAD_SUB,
         array_pkg::FLUSH, array_pkg::DONE, array_pkg::CODE_PAD, array_pkg::CODE_N,
         array_pkg::is_bad_code;
#(
  parameter int LENGTH_CHAR    = 3,
  parameter int CHARS_PER_WORD = 5,
  parameter int WORD_WIDTH     = 16,
  parameter int LENGTH_COUNTER = 8,
  parameter int LENGTH         = 6
) (
  input  logic                      com_clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LENGTH_COUNTER-1:0] query_len,
  input  logic [LENGTH_COUNTER-1:0] sub_len,
  input  logic [WORD_WIDTH-1:0]     in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      in_last,
  output logic [LENGTH_CHAR-1:0]    query_char_out,
  output logic                      query_enable,
  output logic [LENGTH_CHAR-1:0]    sub_char_out,
  output logic                      sub_enable,
  output logic                      busy,
  output logic                      done,
  output logic                      error
);

  localparam int PAYLOAD_W = CHARS_PER_WORD * LENGTH_CHAR;

  state_t                    state, state_next;
  logic [LENGTH_COUNTER-1:0] pos, pos_next, pos_inc;
  logic [LENGTH_COUNTER-1:0] q_len, q_len_next, s_len, s_len_next, cur_len;
  logic                      err_next, done_next;
  logic [LENGTH_CHAR-1:0]    q_char_next, s_char_next, raw_code;
  logic                      q_en_next, s_en_next;

  logic                      u_load, u_advance, u_discard;
  logic                      u_empty, u_last_lane, u_word_last;
  logic [LENGTH_CHAR-1:0]    u_head;

  logic load_state, accept, emit, lane_last, word_end, finish;

  generate
    if (WORD_WIDTH > PAYLOAD_W) begin : g_unused
      logic unused_bits;
      assign unused_bits = ^in_data[WORD_WIDTH-1:PAYLOAD_W];
    end
  endgenerate

  word_unpacker #(
    .LANE_W (LENGTH_CHAR),
    .LANES  (CHARS_PER_WORD)
  ) u_unpacker (
    .com_clk   (com_clk),
    .reset     (reset),
    .load      (u_load),
    .load_data (in_data[PAYLOAD_W-1:0]),
    .load_last (in_last),
    .advance   (u_advance),
    .discard   (u_discard),
    .empty     (u_empty),
    .head      (u_head),
    .last_lane (u_last_lane),
    .word_last (u_word_last)
  );

  assign load_state = (state == LOAD_QUERY) || (state == LOAD_SUB);
  assign in_ready   = load_state && u_empty;
  assign accept     = in_valid && in_ready;
  // Lane 0 of a freshly accepted word bypasses the unpacker so it reaches the
  // output registers on the acceptance edge; later lanes come from the unpacker.
  assign emit       = accept || (load_state && !u_empty);
  assign raw_code   = accept ? in_data[LENGTH_CHAR-1:0] : u_head;
  assign lane_last  = accept ? (CHARS_PER_WORD == 1) : u_last_lane;
  assign word_end   = lane_last && (accept ? in_last : u_word_last);
  assign cur_len    = (state == LOAD_QUERY) ? q_len : s_len;
  assign pos_inc    = pos + 1'b1;
  assign busy       = (state != IDLE);

  always_ff @(posedge com_clk) begin
    if (reset) begin
      state          <= IDLE;
      pos            <= '0;
      q_len          <= '0;
      s_len          <= '0;
      error          <= 1'b0;
      done           <= 1'b0;
      query_char_out <= '0;
      query_enable   <= 1'b0;
      sub_char_out   <= '0;
      sub_enable     <= 1'b0;
    end else begin
      state          <= state_next;
      pos            <= pos_next;
      q_len          <= q_len_next;
      s_len          <= s_len_next;
      error          <= err_next;
      done           <= done_next;
      query_char_out <= q_char_next;
      query_enable   <= q_en_next;
      sub_char_out   <= s_char_next;
      sub_enable     <= s_en_next;
    end
  end

  always_comb begin
    state_next  = state;
    pos_next    = pos;
    q_len_next  = q_len;
    s_len_next  = s_len;
    err_next    = error;
    done_next   = 1'b0;
    q_char_next = '0;
    q_en_next   = 1'b0;
    s_char_next = '0;
    s_en_next   = 1'b0;
    u_load      = 1'b0;
    u_advance   = 1'b0;
    u_discard   = 1'b0;
    finish      = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          q_len_next = query_len;
          s_len_next = sub_len;
          err_next   = 1'b0;
          if ((query_len == '0) || (sub_len == '0)) begin
            err_next   = 1'b1;
            state_next = DONE;
          end else begin
            state_next = LOAD_QUERY;
          end
        end
      end

      LOAD_QUERY, LOAD_SUB: begin
        if (emit) begin
          if (state == LOAD_QUERY) begin
            q_char_next = is_bad_code(raw_code) ? CODE_N : raw_code;
            q_en_next   = 1'b1;
          end else begin
            s_char_next = is_bad_code(raw_code) ? CODE_N : raw_code;
            s_en_next   = 1'b1;
          end
          if (is_bad_code(raw_code)) begin
            err_next = 1'b1;
          end
          if (pos_inc == cur_len) begin
            finish = 1'b1;
          end else if (word_end) begin
            // in_last arrived short of the requested length: truncate.
            finish   = 1'b1;
            err_next = 1'b1;
          end
          if (finish) begin
            pos_next   = '0;
            u_discard  = 1'b1;
            state_next = (state == LOAD_QUERY) ? LOAD_SUB : FLUSH;
          end else begin
            pos_next  = pos_inc;
            u_load    = accept;
            u_advance = !accept;
          end
        end
      end

      FLUSH: begin
        s_char_next = CODE_PAD;
        s_en_next   = 1'b1;
        if (pos_inc == LENGTH_COUNTER'(LENGTH)) begin
          pos_next   = '0;
          state_next = DONE;
        end else begin
          pos_next = pos_inc;
        end
      end

      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end

      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_array_feeder.sv
// tb/tb_array_feeder.sv - scoreboard bench for array_feeder
module tb_array_feeder;

  localparam int LC   = 3;
  localparam int CPW  = 5;
  localparam int WW   = 16;
  localparam int LCNT = 8;
  localparam int LEN  = 6;

  localparam logic [2:0] A = 3'b001;
  localparam logic [2:0] G = 3'b010;
  localparam logic [2:0] T = 3'b011;
  localparam logic [2:0] C = 3'b100;
  localparam logic [2:0] N = 3'b101;

  logic            com_clk = 1'b0;
  logic            reset;
  logic            start;
  logic [LCNT-1:0] query_len;
  logic [LCNT-1:0] sub_len;
  logic [WW-1:0]   in_data;
  logic            in_valid;
  logic            in_ready;
  logic            in_last;
  logic [LC-1:0]   query_char_out;
  logic            query_enable;
  logic [LC-1:0]   sub_char_out;
  logic            sub_enable;
  logic            busy;
  logic            done;
  logic            error;

  array_feeder #(
    .LENGTH_CHAR    (LC),
    .CHARS_PER_WORD (CPW),
    .WORD_WIDTH     (WW),
    .LENGTH_COUNTER (LCNT),
    .LENGTH         (LEN)
  ) dut (
    .com_clk        (com_clk),
    .reset          (reset),
    .start          (start),
    .query_len      (query_len),
    .sub_len        (sub_len),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_last        (in_last),
    .query_char_out (query_char_out),
    .query_enable   (query_enable),
    .sub_char_out   (sub_char_out),
    .sub_enable     (sub_enable),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 com_clk = ~com_clk;

  int          checks = 0;
  int          failures = 0;
  logic [2:0]  exp_q[$];
  logic [2:0]  exp_s[$];
  logic [15:0] qwords[$];
  logic [15:0] swords[$];
  logic        exp_err;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [15:0] pack(input logic [2:0] c0, input logic [2:0] c1,
                                       input logic [2:0] c2, input logic [2:0] c3,
                                       input logic [2:0] c4, input logic top);
    return {top, c4, c3, c2, c1, c0};
  endfunction

  // Output monitor: every emitted code is matched against the scoreboard.
  always @(negedge com_clk) begin
    if (query_enable || sub_enable)
      chk_eq("enable_exclusive", 32'(query_enable & sub_enable), 0);
    if (query_enable) begin
      if (exp_q.size() == 0) chk_eq("query_unexpected", 32'(query_enable), 0);
      else                   chk_eq("query_code", 32'(query_char_out), 32'(exp_q.pop_front()));
    end
    if (sub_enable) begin
      if (exp_s.size() == 0) chk_eq("sub_unexpected", 32'(sub_enable), 0);
      else                   chk_eq("sub_code", 32'(sub_char_out), 32'(exp_s.pop_front()));
    end
  end

  task automatic send_word(input logic [15:0] w, input logic last);
    int n;
    n = 0;
    in_data  = w;
    in_valid = 1'b1;
    in_last  = last;
    while (!in_ready && n < 500) begin
      @(negedge com_clk);
      n++;
    end
    chk_eq("in_ready", 32'(in_ready), 1);
    @(negedge com_clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk_eq("first_code_latency", 32'(query_enable | sub_enable), 1);
  endtask

  // Pushes the expected codes of each word as it is driven; in_last marks the final word.
  task automatic send_seq(input int len, input bit is_q, input int stall_idx);
    int          sent;
    int          nwords;
    logic [15:0] w;
    logic [2:0]  c;
    sent   = 0;
    nwords = is_q ? qwords.size() : swords.size();
    for (int i = 0; i < nwords; i++) begin
      w = is_q ? qwords[i] : swords[i];
      for (int l = 0; l < CPW; l++) begin
        if (sent < len) begin
          c = w[l*LC +: LC];
          if (c == 3'b000 || c == 3'b110 || c == 3'b111) begin
            c       = N;
            exp_err = 1'b1;
          end
          if (is_q) exp_q.push_back(c);
          else      exp_s.push_back(c);
          sent++;
        end
      end
      if (i == nwords - 1) begin
        if (sent < len) exp_err = 1'b1;
        if (!is_q) for (int p = 0; p < LEN; p++) exp_s.push_back(3'b000);
      end
      if (i == stall_idx) repeat (5) @(negedge com_clk);
      send_word(w, i == nwords - 1);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(negedge com_clk);
      n++;
    end
    chk_eq("done_seen", 32'(done), 1);
    chk_eq("error_at_done", 32'(error), 32'(exp_err));
    chk_eq("query_left", 32'(exp_q.size()), 0);
    chk_eq("sub_left", 32'(exp_s.size()), 0);
    chk_eq("busy_at_done", 32'(busy), 0);
    exp_q.delete();
    exp_s.delete();
    @(negedge com_clk);
    chk_eq("done_one_cycle", 32'(done), 0);
  endtask

  task automatic run_job(input int ql, input int sl, input int stall_idx, input bit mid_start);
    exp_err   = 1'b0;
    query_len = LCNT'(ql);
    sub_len   = LCNT'(sl);
    start     = 1'b1;
    @(negedge com_clk);
    start = 1'b0;
    chk_eq("busy_after_start", 32'(busy), 1);
    if (ql == 0 || sl == 0) begin
      exp_err = 1'b1;
      chk_eq("zero_len_no_done_yet", 32'(done), 0);
      @(negedge com_clk);
      chk_eq("zero_len_done_two_cycles", 32'(done), 1);
    end else begin
      send_seq(ql, 1'b1, -1);
      if (mid_start) begin
        query_len = '0;
        start     = 1'b1;
        @(negedge com_clk);
        start = 1'b0;
      end
      send_seq(sl, 1'b0, stall_idx);
    end
    wait_done();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk_eq({tag, "_in_ready"}, 32'(in_ready), 0);
    chk_eq({tag, "_query_char"}, 32'(query_char_out), 0);
    chk_eq({tag, "_query_en"}, 32'(query_enable), 0);
    chk_eq({tag, "_sub_char"}, 32'(sub_char_out), 0);
    chk_eq({tag, "_sub_en"}, 32'(sub_enable), 0);
    chk_eq({tag, "_busy"}, 32'(busy), 0);
    chk_eq({tag, "_done"}, 32'(done), 0);
    chk_eq({tag, "_error"}, 32'(error), 0);
  endtask

  initial begin
    int  n;
    logic saw_done;
    reset     = 1'b1;
    start     = 1'b0;
    query_len = '0;
    sub_len   = '0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    exp_err   = 1'b0;
    repeat (2) @(negedge com_clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    @(negedge com_clk);

    // Basic job: query AGT, subject GTAC, six PAD flush.
    qwords.delete(); swords.delete();
    qwords.push_back(pack(A, G, T, C, N, 1'b0));
    swords.push_back(pack(G, T, A, C, C, 1'b1));
    run_job(3, 4, -1, 1'b0);

    // Two-word query, three-word subject with a 5-cycle stall and a stray start.
    qwords.delete(); swords.delete();
    qwords.push_back(pack(C, A, A, G, T, 1'b0));
    qwords.push_back(pack(T, G, C, A, A, 1'b1));
    swords.push_back(pack(A, C, G, T, A, 1'b1));
    swords.push_back(pack(G, G, C, C, T, 1'b0));
    swords.push_back(pack(T, A, G, C, A, 1'b1));
    run_job(7, 12, 1, 1'b1);

    // Invalid 110 in lane 2 of the query word.
    qwords.delete(); swords.delete();
    qwords.push_back(pack(A, G, 3'b110, T, C, 1'b0));
    swords.push_back(pack(A, A, A, A, A, 1'b0));
    run_job(5, 2, -1, 1'b0);

    // PAD and 111 codes inside the subject.
    qwords.delete(); swords.delete();
    qwords.push_back(pack(G, C, A, A, A, 1'b0));
    swords.push_back(pack(A, 3'b000, G, 3'b111, T, 1'b1));
    run_job(1, 5, -1, 1'b0);

    // Subject truncated by in_last on its first word.
    qwords.delete(); swords.delete();
    qwords.push_back(pack(G, G, T, T, C, 1'b0));
    swords.push_back(pack(A, C, G, T, A, 1'b0));
    run_job(2, 8, -1, 1'b0);

    // Query truncated by in_last, then a full-length subject.
    qwords.delete(); swords.delete();
    qwords.push_back(pack(T, C, G, A, C, 1'b0));
    swords.push_back(pack(C, A, T, G, G, 1'b0));
    run_job(9, 3, -1, 1'b0);

    // Zero query length.
    run_job(0, 5, -1, 1'b0);

    // Reset in the middle of FLUSH.
    qwords.delete(); swords.delete();
    qwords.push_back(pack(A, T, G, G, G, 1'b0));
    swords.push_back(pack(C, G, A, A, A, 1'b0));
    exp_err   = 1'b0;
    query_len = 8'd2;
    sub_len   = 8'd3;
    start     = 1'b1;
    @(negedge com_clk);
    start = 1'b0;
    send_seq(2, 1'b1, -1);
    send_seq(3, 1'b0, -1);
    n = 0;
    while (exp_s.size() > 3 && n < 100) begin
      @(negedge com_clk);
      n++;
    end
    chk_eq("busy_in_flush", 32'(busy), 1);
    chk_eq("sub_en_in_flush", 32'(sub_enable), 1);
    reset = 1'b1;
    @(negedge com_clk);
    check_idle_outputs("abort");
    reset = 1'b0;
    exp_q.delete();
    exp_s.delete();
    saw_done = 1'b0;
    repeat (10) begin
      @(negedge com_clk);
      if (done) saw_done = 1'b1;
    end
    chk_eq("no_done_after_abort", 32'(saw_done), 0);

    // Clean job after the abort.
    qwords.delete(); swords.delete();
    qwords.push_back(pack(C, C, G, A, T, 1'b1));
    swords.push_back(pack(T, T, A, G, C, 1'b0));
    run_job(4, 5, -1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/array_feeder.md
ARRAY_FEEDER -- requirements
Module: array_feeder

Interface
REQ-001 Parameter LENGTH_CHAR, default 3: width of one nucleotide code.
REQ-002 Parameter CHARS_PER_WORD, default 5: codes packed per input word, lane 0 in bits [2:0].
REQ-003 Parameter WORD_WIDTH, default 16: input word width; bits above CHARS_PER_WORD*LENGTH_CHAR are ignored.
REQ-004 Parameter LENGTH_COUNTER, default 8: width of the length and position counters.
REQ-005 Parameter LENGTH, default 6: number of array cells; sets the flush length.
REQ-006 Clock and reset: one clock, com_clk; reset is synchronous and active-high, named reset.
REQ-007 com_clk  in  1  sole clock, all logic on the rising edge.
REQ-008 reset  in  1  synchronous, active-high reset.
REQ-009 start  in  1  one-cycle job start pulse, sampled only in IDLE.
REQ-010 query_len  in  LENGTH_COUNTER  query character count, latched on start.
REQ-011 sub_len  in  LENGTH_COUNTER  subject character count, latched on start.
REQ-012 in_data  in  WORD_WIDTH  packed nucleotide word.
REQ-013 in_valid  in  1  in_data valid.
REQ-014 in_ready  out  1  feeder accepts in_data this cycle.
REQ-015 in_last  in  1  last word of the current sequence.
REQ-016 query_char_out  out  LENGTH_CHAR  query code to the array's first cell.
REQ-017 query_enable  out  1  query_char_out valid this cycle.
REQ-018 sub_char_out  out  LENGTH_CHAR  subject code to the array's first cell.
REQ-019 sub_enable  out  1  sub_char_out valid this cycle.
REQ-020 busy  out  1  high in every state except IDLE.
REQ-021 done  out  1  one-cycle pulse at job end.
REQ-022 error  out  1  sticky fault flag; cleared by start or reset.

Function
REQ-023 FSM states: IDLE, LOAD_QUERY, LOAD_SUB, FLUSH, DONE.
REQ-024 IDLE: start=1 latches both lengths and clears error; go to LOAD_QUERY, or to DONE with error=1 if either length is 0.
REQ-025 in_ready = 1 only in LOAD_QUERY or LOAD_SUB while the unpacker is empty; a word transfers on in_valid & in_ready.
REQ-026 Each word is emitted one code per cycle, lane 0 first; the first code is registered on the outputs in the cycle after acceptance.
REQ-027 LOAD_QUERY: each emitted code drives query_enable=1; the position counter increments once per code.
REQ-028 When the count reaches query_len, unused lanes are discarded, the counter clears and the FSM goes to LOAD_SUB in the next cycle.
REQ-029 LOAD_SUB: the same rules apply using sub_enable and sub_len; on reaching sub_len the FSM goes to FLUSH.
REQ-030 An in_last word that ends before the length is reached truncates the sequence, sets error and advances the state as if the length had been reached.
REQ-031 Codes 000, 110 and 111 in a word are emitted as N (101) and set error.
REQ-032 FLUSH: for exactly LENGTH cycles, drive sub_enable=1 with sub_char_out=000 to push subject data out of the array.
REQ-033 DONE: assert done for one cycle, then return to IDLE.
REQ-034 query_enable and sub_enable are never high in the same cycle; both are 0 when no code is emitted (bubble).
REQ-035 start outside IDLE is ignored.
REQ-036 Counter arithmetic is unsigned LENGTH_COUNTER wide; lengths up to 2^LENGTH_COUNTER-1 are legal and there is no wrap within a job.

Reset
REQ-037 reset=1 (checked first, overriding all other inputs) forces IDLE and clears the unpacker, counters, lengths and error.
REQ-038 Outputs after reset: in_ready=0, query_char_out=0, query_enable=0, sub_char_out=0, sub_enable=0, busy=0, done=0, error=0.
REQ-039 reset mid-job aborts the job immediately, with no flush and no done pulse.

Structure
REQ-040 Shared package array_pkg holds: nucleotide codes A=001, G=010, T=011, C=100, N=101; PAD=000; and LENGTH_CHAR.
REQ-041 One sub-module, word_unpacker, contains the word shift register and lane-remaining count, and provides a load/advance/discard interface.

Verification
REQ-042 query_len=3, sub_len=4, words A,G,T,C,N then G,T,A,C,C -> query A,G,T on 3 consecutive query_enable cycles; subject G,T,A,C; 6 PAD flush cycles; done; error=0.
REQ-043 Hold in_valid low for 5 cycles mid-subject -> sub_enable=0 for the stall, the order of codes is kept, and the total subject count is unchanged.
REQ-044 Word containing 110 in lane 2 -> N (101) is emitted in that position and error=1 at done.
REQ-045 sub_len=8 with in_last on the first subject word -> 5 subject codes emitted, then FLUSH, done, error=1.
REQ-046 reset asserted during FLUSH -> the next cycle shows all outputs 0 and busy=0, and a subsequent start runs a clean job.
REQ-047 start with query_len=0 -> no enables asserted, done pulses 2 cycles later, error=1.
